// File: rtl/uart_tx_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_stream                                                  |
// | Purpose  : Byte-stream UART transmitter. Bytes arrive over a valid/ready   |
// |            handshake into a one-byte holding register and are shifted out  |
// |            as 8-bit frames (start, 8 data LSB first, optional parity,       |
// |            stop). Frames whose byte is already held go out back-to-back.   |
// |            frame_done pulses after every FRAME_BYTES transmitted bytes.    |
// | Ports    : clk        - system clock, rising edge                          |
// |            reset      - asynchronous, active-low reset                     |
// |            data_in    - byte to transmit                                   |
// |            data_valid - data_in is valid this cycle                        |
// |            ready_tx   - holding register empty, a byte can be taken        |
// |            tx         - registered UART line, idles high                   |
// |            busy       - frame in progress or byte held                     |
// |            frame_done - one-cycle pulse when FRAME_BYTES-th byte completes |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_BYTES  = 16,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ready_tx,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES + 1) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic              PARITY_EN  = (PARITY != 0);
  localparam logic              PARITY_ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [7:0]        shift_q, shift_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              tx_q, tx_d;
  logic              frame_done_q, frame_done_d;

  logic accept;
  logic load;
  logic bit_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      hold_q       <= 8'h00;
      hold_full_q  <= 1'b0;
      shift_q      <= 8'h00;
      baud_q       <= '0;
      bit_idx_q    <= 3'd0;
      byte_cnt_q   <= '0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    baud_d       = baud_q;
    bit_idx_d    = bit_idx_q;
    byte_cnt_d   = byte_cnt_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    // Accept only into an empty holder; loads only happen from a full one,
    // so the two can never collide on the same edge.
    accept       = data_valid && !hold_full_q;
    bit_end      = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_ONE;
    end

    // tx_d is the line value for the cycle after this edge, which keeps tx
    // a clean register output.
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = S_PARITY;
              tx_d    = (^shift_q) ^ PARITY_ODD;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_cnt_q == CNT_LAST) begin
            byte_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_ONE;
          end
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Shared by the idle start and the back-to-back start from STOP.
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      state_d     = S_START;
      tx_d        = 1'b0;
      baud_d      = '0;
      bit_idx_d   = 3'd0;
    end

    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  assign ready_tx   = ~hold_full_q;
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || hold_full_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
